// File: rtl/riscv_trace_pkg.sv
// Shared types and encodings for the retirement trace generator.
// Holds the registered trace bundle layout, mode/breakpoint codes and error bit positions.
package riscv_trace_pkg;

   localparam logic [2:0] MODE_U = 3'd0;
   localparam logic [2:0] MODE_S = 3'd1;
   localparam logic [2:0] MODE_M = 3'd3;
   localparam logic [2:0] MODE_D = 3'd4;

   localparam logic [3:0] BKPT_NONE    = 4'h0;
   localparam logic [3:0] BKPT_TRIGGER = 4'h1;
   localparam logic [3:0] BKPT_EBREAK  = 4'h2;
   localparam logic [3:0] BKPT_HALTREQ = 4'h3;

   localparam int ERR_DEFER_OVF = 0;
   localparam int ERR_HOLD_OVF  = 1;
   localparam int ERR_UNEXP_WB  = 2;

   typedef struct packed {
      logic        instr_valid;
      logic [2:0]  mode;
      logic [31:0] instr_pc;
      logic [31:0] instruction;
      logic        branch_taken;
      logic [31:0] branch_target;
      logic        trap;
      logic        ret;
      logic        jalr;
      logic        rfw_retire;
      logic        rfw_data_valid;
      logic [4:0]  rfw_rd;
      logic [31:0] rfw_data;
      logic        bkpt_valid;
      logic [3:0]  bkpt_reason;
   } t_riscv_trace;

endpackage

// File: rtl/riscv_trace_wb_tracker.sv
// Tracks the single outstanding deferred write and a one-entry hold for writebacks that
// lose the rfw port to a retire; decides which writeback (if any) is emitted this cycle.
module riscv_trace_wb_tracker
   import riscv_trace_pkg::*;
(
   input  logic        clk,
   input  logic        i_en,
   input  logic        i_rst_n,
   input  logic        i_port_busy,
   input  logic        i_defer_vld,
   input  logic [4:0]  i_defer_rd,
   input  logic        i_wb_vld,
   input  logic [4:0]  i_wb_rd,
   input  logic [31:0] i_wb_data,
   output logic        o_emit_vld,
   output logic [4:0]  o_emit_rd,
   output logic [31:0] o_emit_data,
   output logic        o_busy,
   output logic [2:0]  o_err
);

   logic        r_pend_vld;
   logic [4:0]  r_pend_rd;
   logic        r_hold_vld;
   logic [4:0]  r_hold_rd;
   logic [31:0] r_hold_data;
   logic [2:0]  r_err;

   logic        w_hold_load;
   logic        w_hold_clr;
   logic [2:0]  w_err_set;

   always_comb begin
      o_emit_vld  = 1'b0;
      o_emit_rd   = 5'd0;
      o_emit_data = 32'd0;
      w_hold_load = 1'b0;
      w_hold_clr  = 1'b0;
      // Held data drains ahead of a new wb, which then takes the freed slot.
      if (!i_port_busy && r_hold_vld) begin
         o_emit_vld  = 1'b1;
         o_emit_rd   = r_hold_rd;
         o_emit_data = r_hold_data;
         w_hold_clr  = 1'b1;
         w_hold_load = i_wb_vld;
      end else if (!i_port_busy && i_wb_vld) begin
         o_emit_vld  = 1'b1;
         o_emit_rd   = i_wb_rd;
         o_emit_data = i_wb_data;
      end else if (i_port_busy && i_wb_vld && !r_hold_vld) begin
         w_hold_load = 1'b1;
      end
   end

   always_comb begin
      w_err_set                = 3'd0;
      w_err_set[ERR_DEFER_OVF] = i_defer_vld && r_pend_vld && !i_wb_vld;
      w_err_set[ERR_HOLD_OVF]  = i_port_busy && i_wb_vld && r_hold_vld;
      w_err_set[ERR_UNEXP_WB]  = i_wb_vld && (!r_pend_vld || (i_wb_rd != r_pend_rd));
   end

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (!i_rst_n) begin
            r_pend_vld  <= 1'b0;
            r_pend_rd   <= 5'd0;
            r_hold_vld  <= 1'b0;
            r_hold_rd   <= 5'd0;
            r_hold_data <= 32'd0;
            r_err       <= 3'd0;
         end else begin
            if (w_hold_load) begin
               r_hold_vld  <= 1'b1;
               r_hold_rd   <= i_wb_rd;
               r_hold_data <= i_wb_data;
            end else if (w_hold_clr) begin
               r_hold_vld  <= 1'b0;
            end
            // A wb retires the old pending entry before a same-cycle deferral refills it.
            if (i_defer_vld) begin
               r_pend_vld <= 1'b1;
               r_pend_rd  <= i_defer_rd;
            end else if (i_wb_vld) begin
               r_pend_vld <= 1'b0;
            end
            r_err <= r_err | w_err_set;
         end
      end
   end

   assign o_busy = r_pend_vld || r_hold_vld;
   assign o_err  = r_err;

endmodule

// File: rtl/riscv_trace_gen.sv
// Registers one trace record per retired instruction, one enabled cycle after sampling.
// Optional breakpoint path is compiled in with RISCV_TRACE_BKPT_EN.
module riscv_trace_gen
   import riscv_trace_pkg::*;
(
   input  logic        clk,
   input  logic        clk__enable,
   input  logic        reset_n,
   input  logic        ret_valid,
   input  logic [31:0] ret_pc,
   input  logic [31:0] ret_instr,
   input  logic [2:0]  ret_mode,
   input  logic        ret_branch_taken,
   input  logic [31:0] ret_branch_target,
   input  logic        ret_trap,
   input  logic        ret_ret,
   input  logic        ret_jalr,
   input  logic [4:0]  ret_rd,
   input  logic        ret_rd_written,
   input  logic [31:0] ret_rd_data,
   input  logic        ret_rd_deferred,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        bkpt_in_valid,
   input  logic [3:0]  bkpt_in_reason,
   output logic        trace__instr_valid,
   output logic [2:0]  trace__mode,
   output logic [31:0] trace__instr_pc,
   output logic [31:0] trace__instruction,
   output logic        trace__branch_taken,
   output logic [31:0] trace__branch_target,
   output logic        trace__trap,
   output logic        trace__ret,
   output logic        trace__jalr,
   output logic        trace__rfw_retire,
   output logic        trace__rfw_data_valid,
   output logic [4:0]  trace__rfw_rd,
   output logic [31:0] trace__rfw_data,
   output logic        trace__bkpt_valid,
   output logic [3:0]  trace__bkpt_reason,
   output logic        wb_busy,
   output logic [2:0]  trace_err
);

   t_riscv_trace r_trace;
   t_riscv_trace w_next;

   logic        w_imm;
   logic        w_defer;
   logic        w_emit_vld;
   logic [4:0]  w_emit_rd;
   logic [31:0] w_emit_data;

   assign w_imm   = ret_valid && ret_rd_written && (ret_rd != 5'd0);
   assign w_defer = ret_valid && ret_rd_deferred && !ret_rd_written && (ret_rd != 5'd0);

   // Deferred retires also occupy the rfw port (they report rd), so wbs wait for them too.
   riscv_trace_wb_tracker u_wb_tracker (
      .clk         (clk),
      .i_en        (clk__enable),
      .i_rst_n     (reset_n),
      .i_port_busy (w_imm || w_defer),
      .i_defer_vld (w_defer),
      .i_defer_rd  (ret_rd),
      .i_wb_vld    (wb_valid),
      .i_wb_rd     (wb_rd),
      .i_wb_data   (wb_data),
      .o_emit_vld  (w_emit_vld),
      .o_emit_rd   (w_emit_rd),
      .o_emit_data (w_emit_data),
      .o_busy      (wb_busy),
      .o_err       (trace_err)
   );

   always_comb begin
      w_next = '0;
      if (ret_valid) begin
         w_next.instr_valid   = 1'b1;
         w_next.mode          = ret_mode;
         w_next.instr_pc      = ret_pc;
         w_next.instruction   = ret_instr;
         w_next.branch_taken  = ret_branch_taken;
         w_next.branch_target = ret_branch_target;
         w_next.trap          = ret_trap;
         w_next.ret           = ret_ret;
         w_next.jalr          = ret_jalr;
      end
      if (w_imm) begin
         w_next.rfw_retire     = 1'b1;
         w_next.rfw_data_valid = 1'b1;
         w_next.rfw_rd         = ret_rd;
         w_next.rfw_data       = ret_rd_data;
      end else if (w_defer) begin
         w_next.rfw_retire     = 1'b1;
         w_next.rfw_rd         = ret_rd;
      end else if (w_emit_vld) begin
         w_next.rfw_data_valid = 1'b1;
         w_next.rfw_rd         = w_emit_rd;
         w_next.rfw_data       = w_emit_data;
      end
`ifdef RISCV_TRACE_BKPT_EN
      w_next.bkpt_valid  = bkpt_in_valid;
      w_next.bkpt_reason = bkpt_in_valid ? bkpt_in_reason : BKPT_NONE;
`endif
   end

`ifndef RISCV_TRACE_BKPT_EN
   logic w_unused_bkpt;
   assign w_unused_bkpt = &{1'b0, bkpt_in_valid, bkpt_in_reason};
`endif

   always_ff @(posedge clk) begin
      if (clk__enable) begin
         if (!reset_n) begin
            r_trace <= '0;
         end else begin
            r_trace <= w_next;
         end
      end
   end

   assign trace__instr_valid    = r_trace.instr_valid;
   assign trace__mode           = r_trace.mode;
   assign trace__instr_pc       = r_trace.instr_pc;
   assign trace__instruction    = r_trace.instruction;
   assign trace__branch_taken   = r_trace.branch_taken;
   assign trace__branch_target  = r_trace.branch_target;
   assign trace__trap           = r_trace.trap;
   assign trace__ret            = r_trace.ret;
   assign trace__jalr           = r_trace.jalr;
   assign trace__rfw_retire     = r_trace.rfw_retire;
   assign trace__rfw_data_valid = r_trace.rfw_data_valid;
   assign trace__rfw_rd         = r_trace.rfw_rd;
   assign trace__rfw_data       = r_trace.rfw_data;
   assign trace__bkpt_valid     = r_trace.bkpt_valid;
   assign trace__bkpt_reason    = r_trace.bkpt_reason;

endmodule

// File: tb/tb_riscv_trace_gen.sv
// Directed bench for riscv_trace_gen; breakpoint expectations follow RISCV_TRACE_BKPT_EN.
module tb_riscv_trace_gen;
   import riscv_trace_pkg::*;

   logic        clk = 1'b0;
   logic        clk__enable;
   logic        reset_n;
   logic        ret_valid;
   logic [31:0] ret_pc;
   logic [31:0] ret_instr;
   logic [2:0]  ret_mode;
   logic        ret_branch_taken;
   logic [31:0] ret_branch_target;
   logic        ret_trap;
   logic        ret_ret;
   logic        ret_jalr;
   logic [4:0]  ret_rd;
   logic        ret_rd_written;
   logic [31:0] ret_rd_data;
   logic        ret_rd_deferred;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        bkpt_in_valid;
   logic [3:0]  bkpt_in_reason;
   logic        trace__instr_valid;
   logic [2:0]  trace__mode;
   logic [31:0] trace__instr_pc;
   logic [31:0] trace__instruction;
   logic        trace__branch_taken;
   logic [31:0] trace__branch_target;
   logic        trace__trap;
   logic        trace__ret;
   logic        trace__jalr;
   logic        trace__rfw_retire;
   logic        trace__rfw_data_valid;
   logic [4:0]  trace__rfw_rd;
   logic [31:0] trace__rfw_data;
   logic        trace__bkpt_valid;
   logic [3:0]  trace__bkpt_reason;
   logic        wb_busy;
   logic [2:0]  trace_err;

   int n_checks = 0;
   int n_errors = 0;

   riscv_trace_gen dut (
      .clk(clk), .clk__enable(clk__enable), .reset_n(reset_n),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_mode(ret_mode),
      .ret_branch_taken(ret_branch_taken), .ret_branch_target(ret_branch_target),
      .ret_trap(ret_trap), .ret_ret(ret_ret), .ret_jalr(ret_jalr),
      .ret_rd(ret_rd), .ret_rd_written(ret_rd_written), .ret_rd_data(ret_rd_data),
      .ret_rd_deferred(ret_rd_deferred),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .bkpt_in_valid(bkpt_in_valid), .bkpt_in_reason(bkpt_in_reason),
      .trace__instr_valid(trace__instr_valid), .trace__mode(trace__mode),
      .trace__instr_pc(trace__instr_pc), .trace__instruction(trace__instruction),
      .trace__branch_taken(trace__branch_taken), .trace__branch_target(trace__branch_target),
      .trace__trap(trace__trap), .trace__ret(trace__ret), .trace__jalr(trace__jalr),
      .trace__rfw_retire(trace__rfw_retire), .trace__rfw_data_valid(trace__rfw_data_valid),
      .trace__rfw_rd(trace__rfw_rd), .trace__rfw_data(trace__rfw_data),
      .trace__bkpt_valid(trace__bkpt_valid), .trace__bkpt_reason(trace__bkpt_reason),
      .wb_busy(wb_busy), .trace_err(trace_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ret_valid = 0; ret_pc = 0; ret_instr = 0; ret_mode = 0;
      ret_branch_taken = 0; ret_branch_target = 0;
      ret_trap = 0; ret_ret = 0; ret_jalr = 0;
      ret_rd = 0; ret_rd_written = 0; ret_rd_data = 0; ret_rd_deferred = 0;
      wb_valid = 0; wb_rd = 0; wb_data = 0;
      bkpt_in_valid = 0; bkpt_in_reason = 0;
   endtask

   task automatic retire_imm(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
      ret_valid = 1; ret_pc = pc; ret_instr = 32'h0000_0013; ret_mode = MODE_M;
      ret_rd = rd; ret_rd_written = 1; ret_rd_data = d; ret_rd_deferred = 0;
   endtask

   task automatic retire_def(input logic [31:0] pc, input logic [4:0] rd);
      ret_valid = 1; ret_pc = pc; ret_instr = 32'h0000_2003; ret_mode = MODE_M;
      ret_rd = rd; ret_rd_written = 0; ret_rd_data = 0; ret_rd_deferred = 1;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      wb_valid = 1; wb_rd = rd; wb_data = d;
   endtask

   task automatic chk_rfw(input string tag, input logic ret, input logic dv,
                          input logic [4:0] rd, input logic [31:0] d);
      check_val({tag, ".retire"}, trace__rfw_retire, ret);
      check_val({tag, ".dv"}, trace__rfw_data_valid, dv);
      check_val({tag, ".rd"}, trace__rfw_rd, rd);
      check_val({tag, ".data"}, trace__rfw_data, d);
   endtask

   task automatic do_reset();
      idle();
      reset_n = 0;
      tick();
      tick();
      reset_n = 1;
   endtask

   initial begin
      clk__enable = 1;
      do_reset();
      check_val("rst.instr_valid", trace__instr_valid, 0);
      check_val("rst.pc", trace__instr_pc, 0);
      chk_rfw("rst", 0, 0, 0, 0);
      check_val("rst.busy", wb_busy, 0);
      check_val("rst.err", trace_err, 0);

      // ALU retire with branch/class fields
      retire_imm(32'h100, 5'd5, 32'hDEADBEEF);
      ret_branch_taken = 1; ret_branch_target = 32'h140; ret_jalr = 1;
      tick();
      check_val("alu.instr_valid", trace__instr_valid, 1);
      check_val("alu.pc", trace__instr_pc, 32'h100);
      check_val("alu.mode", trace__mode, 3);
      check_val("alu.btgt", trace__branch_target, 32'h140);
      check_val("alu.jalr", trace__jalr, 1);
      chk_rfw("alu", 1, 1, 5, 32'hDEADBEEF);
      idle();
      tick();
      check_val("idle.instr_valid", trace__instr_valid, 0);
      check_val("idle.pc", trace__instr_pc, 0);
      check_val("idle.btgt", trace__branch_target, 0);
      chk_rfw("idle", 0, 0, 0, 0);

      // load: deferred rd=7, wb two cycles later
      retire_def(32'h104, 5'd7);
      tick();
      chk_rfw("ld.ret", 1, 0, 7, 0);
      check_val("ld.busy1", wb_busy, 1);
      idle();
      tick();
      check_val("ld.gap", trace__rfw_retire, 0);
      wb(5'd7, 32'h1234);
      tick();
      chk_rfw("ld.wb", 0, 1, 7, 32'h1234);
      check_val("ld.busy0", wb_busy, 0);
      check_val("ld.err", trace_err, 0);
      idle();

      // collision: wb rd=7 with immediate rd=3
      retire_def(32'h108, 5'd7);
      tick();
      idle();
      retire_imm(32'h10C, 5'd3, 32'hAAAA);
      wb(5'd7, 32'h5678);
      tick();
      chk_rfw("col.imm", 1, 1, 3, 32'hAAAA);
      check_val("col.busy", wb_busy, 1);
      idle();
      tick();
      chk_rfw("col.held", 0, 1, 7, 32'h5678);
      check_val("col.busy0", wb_busy, 0);
      check_val("col.err", trace_err, 0);

      // x0 suppression
      retire_imm(32'h110, 5'd0, 32'h5555);
      tick();
      check_val("x0.iv", trace__instr_valid, 1);
      chk_rfw("x0", 0, 0, 0, 0);
      check_val("x0.busy", wb_busy, 0);

      // clock enable hold
      retire_imm(32'h200, 5'd4, 32'h4444);
      tick();
      clk__enable = 0;
      retire_def(32'h300, 5'd6);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("en.pc", trace__instr_pc, 32'h200);
         chk_rfw("en", 1, 1, 4, 32'h4444);
         check_val("en.busy", wb_busy, 0);
      end
      clk__enable = 1;
      idle();
      tick();

      // errors: defer overflow, mismatched wb, hold overflow
      retire_def(32'h400, 5'd7);
      tick();
      retire_def(32'h404, 5'd7);
      tick();
      check_val("err.ovf", trace_err, 3'b001);
      idle();
      wb(5'd9, 32'h99);
      tick();
      check_val("err.mis", trace_err, 3'b101);
      chk_rfw("err.wb", 0, 1, 9, 32'h99);
      idle();
      tick();
      tick();
      check_val("err.sticky", trace_err, 3'b101);
      retire_imm(32'h410, 5'd3, 32'h33);
      wb(5'd10, 32'hA0);
      tick();
      retire_imm(32'h414, 5'd4, 32'h44);
      wb(5'd11, 32'hB0);
      tick();
      chk_rfw("hov.imm", 1, 1, 4, 32'h44);
      check_val("hov.err", trace_err, 3'b111);
      idle();
      tick();
      chk_rfw("hov.old", 0, 1, 10, 32'hA0);
      check_val("hov.busy", wb_busy, 0);

      // reset mid-deferral
      retire_def(32'h500, 5'd7);
      tick();
      do_reset();
      check_val("rst2.err", trace_err, 0);
      check_val("rst2.busy", wb_busy, 0);
      chk_rfw("rst2", 0, 0, 0, 0);
      wb(5'd7, 32'h77);
      tick();
      check_val("rst2.wberr", trace_err, 3'b100);
      chk_rfw("rst2.wb", 0, 1, 7, 32'h77);
      idle();

      // breakpoint, independent of ret_valid
      bkpt_in_valid = 1; bkpt_in_reason = BKPT_EBREAK;
      tick();
      check_val("bk.iv", trace__instr_valid, 0);
`ifdef RISCV_TRACE_BKPT_EN
      check_val("bk.valid", trace__bkpt_valid, 1);
      check_val("bk.reason", trace__bkpt_reason, 2);
`else
      check_val("bk.valid", trace__bkpt_valid, 0);
      check_val("bk.reason", trace__bkpt_reason, 0);
`endif
      idle();
      tick();
      check_val("bk.clr", trace__bkpt_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
